// File: rtl/multi_edge_incr_gen_pkg.sv
// Shared edge-mode encoding used by the multi-channel edge-to-increment generator.
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

endpackage

// File: rtl/multi_edge_incr_gen_ch.sv
// Single channel: optional synchroniser, glitch filter, edge qualifier and
// saturating event counter.
module edge_pulse_ch
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_i,
    input  logic [1:0]       mode_i,
    input  logic             cnt_clr_i,
    output logic             incr_o,
    output logic             level_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic             cnt_sat_o
);

    localparam int FW_RAW = $clog2(FILTER_CYCLES + 1);
    localparam int FW     = (FW_RAW < 1) ? 1 : FW_RAW;
    localparam logic [FW-1:0]    FC_L     = FW'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             y;
    logic             level_q, level_d;
    logic [FW-1:0]    run_q, run_d;
    logic             incr_q, incr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             rise, fall, qual;
    logic [CNT_W-1:0] cnt_inc;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign y = line_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= line_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end
            assign y = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A new level is accepted only after it has persisted FILTER_CYCLES cycles.
    always_comb begin
        level_d = level_q;
        run_d   = run_q;
        if (y == level_q) begin
            run_d = '0;
        end else if (run_q + FW'(1) == FC_L) begin
            level_d = y;
            run_d   = '0;
        end else begin
            run_d = run_q + FW'(1);
        end
    end

    assign rise    = ~level_q & level_d;
    assign fall    = level_q & ~level_d;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        qual = 1'b0;
        case (edge_mode_e'(mode_i))
            MODE_OFF:  qual = 1'b0;
            MODE_RISE: qual = rise;
            MODE_FALL: qual = fall;
            MODE_BOTH: qual = rise | fall;
            default:   qual = 1'b0;
        endcase
    end

    // Clear together with an edge loads 1 so the coincident event survives.
    always_comb begin
        incr_d = qual;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        if (cnt_clr_i) begin
            cnt_d = qual ? CNT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (qual && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            run_q   <= '0;
            incr_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            run_q   <= run_d;
            incr_q  <= incr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign incr_o    = incr_q;
    assign level_o   = level_q;
    assign evt_cnt_o = cnt_q;
    assign cnt_sat_o = sat_q;

endmodule

// File: rtl/multi_edge_incr_gen.sv
// Multi-channel edge-to-increment pulse generator; one independent
// edge_pulse_ch per channel, packed buses sliced per channel.
module multi_edge_incr_gen
    import edge_pulse_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       i_line,
    input  logic [2*CHANNELS-1:0]     i_mode,
    input  logic [CHANNELS-1:0]       i_cnt_clr,
    output logic [CHANNELS-1:0]       o_incr,
    output logic [CHANNELS-1:0]       o_level,
    output logic [CHANNELS*CNT_W-1:0] o_evt_cnt,
    output logic [CHANNELS-1:0]       o_cnt_sat
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            edge_pulse_ch #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .line_i   (i_line[gi]),
                .mode_i   (i_mode[2*gi +: 2]),
                .cnt_clr_i(i_cnt_clr[gi]),
                .incr_o   (o_incr[gi]),
                .level_o  (o_level[gi]),
                .evt_cnt_o(o_evt_cnt[CNT_W*gi +: CNT_W]),
                .cnt_sat_o(o_cnt_sat[gi])
            );
        end
    endgenerate

endmodule
